// File: rtl/bin2bcd_scan.sv
// Sequential double-dabble binary-to-BCD converter with a free-running digit
// scanner that drives one W/X/Y/Z nibble, a blanking enable and a digit select.
module bin2bcd_scan #(
  parameter int unsigned WIDTH    = 14,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  W,
  output logic                  X,
  output logic                  Y,
  output logic                  Z,
  output logic                  en,
  output logic [DIGITS-1:0]     dig_sel
);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SH_W  = BCD_W + WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [SH_W-1:0]   sh_q, sh_d, sh_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        nib_q, nib_d;
  logic              en_q, en_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [DIGITS-1:0] lead_nz;
  logic              nz_acc;
  logic              nz_sel;

  // Conversion FSM: next state, datapath and registered outputs
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    sh_adj     = sh_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d       = {BCD_W'(0), bin};
          cnt_d      = CNT_W'(WIDTH);
          ovf_pend_d = (64'(bin) > MAX_VAL);
          busy_d     = 1'b1;
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        for (int unsigned d = 0; d < DIGITS; d++) begin
          if (sh_q[WIDTH+4*d +: 4] >= 4'd5)
            sh_adj[WIDTH+4*d +: 4] = sh_q[WIDTH+4*d +: 4] + 4'd3;
        end
        sh_d  = sh_adj << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Result is published on entry to DONE so it is visible with done
          bcd_d   = sh_d[SH_W-1 -: BCD_W];
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Scanner: divider, digit index, leading-zero blanking and output nibble
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    nz_acc = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nz_acc     = nz_acc | (|bcd_q[4*i +: 4]);
      lead_nz[i] = nz_acc;
    end
    nib_d  = 4'd0;
    nz_sel = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_d  = bcd_q[4*i +: 4];
        nz_sel = lead_nz[i] | (i == 0);
      end
    end
    en_d  = ~ovf_q & nz_sel;
    sel_d = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      div_q      <= '0;
      idx_q      <= '0;
      nib_q      <= 4'd0;
      en_q       <= 1'b1;
      sel_q      <= ~DIGITS'(1);
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      nib_q      <= nib_d;
      en_q       <= en_d;
      sel_q      <= sel_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign ovf          = ovf_q;
  assign bcd_out      = bcd_q;
  assign {W, X, Y, Z} = nib_q;
  assign en           = en_q;
  assign dig_sel      = sel_q;

endmodule

// File: tb/tb_bin2bcd_scan.sv
// Directed self-checking bench for bin2bcd_scan with a short scan divider.
module tb_bin2bcd_scan;

  localparam int unsigned SD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic        busy, done, ovf;
  logic [15:0] bcd_out;
  logic        W, X, Y, Z, en;
  logic [3:0]  dig_sel;

  int tests = 0;
  int fails = 0;

  bin2bcd_scan #(.WIDTH(14), .DIGITS(4), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .ovf(ovf), .bcd_out(bcd_out),
    .W(W), .X(X), .Y(Y), .Z(Z), .en(en), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Start one conversion and check latency, busy span and the latched result
  task automatic convert(input int v, input logic [15:0] exp_bcd, input logic exp_ovf,
                         input logic chk_bcd);
    int k;
    int busy_cnt;
    start = 1'b1;
    bin   = 14'(v);
    tick();
    start = 1'b0;
    k = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && k < 40) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      k++;
    end
    chk("done_cycle", 32'(k), 15);
    chk("busy_cycles", 32'(busy_cnt), 14);
    chk("busy_in_done", 32'(busy), 0);
    chk("ovf", 32'(ovf), 32'(exp_ovf));
    if (chk_bcd) chk("bcd_out", 32'(bcd_out), 32'(exp_bcd));
    tick();
    chk("done_pulse_end", 32'(done), 0);
  endtask

  // Observe a full frame and check each digit's nibble and enable
  task automatic check_scan(input logic [15:0] exp_nib, input logic [3:0] exp_en,
                            input logic [3:0] nib_mask);
    logic [3:0]  seen;
    logic [15:0] nib_seen;
    logic [3:0]  en_seen;
    logic [3:0]  sel_exp;
    logic        bad_sel;
    int          idx;
    seen = '0; nib_seen = '0; en_seen = '0; bad_sel = 1'b0;
    tick();
    tick();
    for (int c = 0; c < int'(4 * SD) + 2; c++) begin
      tick();
      idx = -1;
      for (int d = 0; d < 4; d++) begin
        sel_exp = 4'b1111;
        sel_exp[d] = 1'b0;
        if (dig_sel === sel_exp) idx = d;
      end
      if (idx >= 0) begin
        seen[idx] = 1'b1;
        nib_seen[4*idx +: 4] = {W, X, Y, Z};
        en_seen[idx] = en;
      end else begin
        bad_sel = 1'b1;
      end
    end
    chk("scan_sel_onehot", 32'(bad_sel), 0);
    chk("scan_all_digits", 32'(seen), 32'hf);
    for (int d = 0; d < 4; d++) begin
      if (nib_mask[d]) chk($sformatf("scan_nib%0d", d), 32'(nib_seen[4*d +: 4]), 32'(exp_nib[4*d +: 4]));
      chk($sformatf("scan_en%0d", d), 32'(en_seen[d]), 32'(exp_en[d]));
    end
  endtask

  initial begin
    logic [3:0] sel_exp;
    int d;
    int nd;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_bcd", 32'(bcd_out), 0);
    chk("rst_sel", 32'(dig_sel), 32'he);
    chk("rst_wxyz", 32'({W, X, Y, Z}), 0);
    chk("rst_en", 32'(en), 1);
    rst_n = 1'b1;

    // Cycle-exact scan from reset: each digit held SD cycles
    for (int k = 1; k <= int'(4 * SD); k++) begin
      tick();
      d = ((k - 1) / int'(SD)) % 4;
      sel_exp = 4'b1111;
      sel_exp[d] = 1'b0;
      chk($sformatf("idle_sel_k%0d", k), 32'(dig_sel), 32'(sel_exp));
      chk($sformatf("idle_en_k%0d", k), 32'(en), (d == 0) ? 1 : 0);
      chk($sformatf("idle_wxyz_k%0d", k), 32'({W, X, Y, Z}), 0);
    end

    convert(1234, 16'h1234, 1'b0, 1'b1);
    check_scan(16'h1234, 4'b1111, 4'b1111);

    convert(9999, 16'h9999, 1'b0, 1'b1);
    convert(10000, 16'h0000, 1'b1, 1'b0);
    check_scan(16'h0000, 4'b0000, 4'b0000);
    convert(7, 16'h0007, 1'b0, 1'b1);
    check_scan(16'h0007, 4'b0001, 4'b1111);

    convert(16383, 16'h0000, 1'b1, 1'b0);
    convert(305, 16'h0305, 1'b0, 1'b1);
    check_scan(16'h0305, 4'b0111, 4'b1111);

    // start held high with bin changing every cycle: samples at edges 0, 16, 32
    start = 1'b1;
    bin   = 14'(1000);
    for (int e = 0; e < 48; e++) begin
      tick();
      chk($sformatf("hold_done_e%0d", e), 32'(done), ((e % 16) == 14) ? 1 : 0);
      if ((e % 16) == 14)
        chk($sformatf("hold_bcd_e%0d", e), 32'(bcd_out), 32'(to_bcd(1000 + 7 * (e - 14))));
      bin = 14'(1000 + 7 * (e + 1));
    end
    start = 1'b0;
    tick();

    // Async reset mid-conversion aborts without a done pulse
    start = 1'b1;
    bin   = 14'(4321);
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_bcd", 32'(bcd_out), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sel", 32'(dig_sel), 32'he);
    tick();
    tick();
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done === 1'b1) nd++;
    end
    chk("abort_no_done", 32'(nd), 0);
    convert(4321, 16'h4321, 1'b0, 1'b1);
    check_scan(16'h4321, 4'b1111, 4'b1111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin2bcd_scan.md
# bin2bcd_scan

Sequential binary-to-BCD encoder and digit scanner that feeds the BCD-to-7-segment decoder. It accepts a binary value on a start strobe and converts it with a shift-and-add-3 (double-dabble) engine. The result is latched, and the block time-multiplexes the digits onto one W/X/Y/Z nibble with a per-digit enable and an active-low digit select. It sits between the datapath (for example, received UART bytes or counters) and the segment decoder/display pins.

## Interface
- WIDTH, 14, binary input width.
- DIGITS, 4, number of BCD digits and display positions.
- SCAN_DIV, 50000, clock cycles each digit is driven (must be ≥2).

- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  conversion request, sampled with bin.
- bin  in  WIDTH  unsigned value to convert.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when bcd_out is updated.
- ovf  out  1  latched; last conversion exceeded 10^DIGITS−1.
- bcd_out  out  4*DIGITS  latched BCD result; digit 0 is in bits [3:0].
- W,X,Y,Z  out  1 each  BCD nibble of the currently scanned digit; W is the MSB, Z is the LSB.
- en  out  1  decoder enable for the scanned digit; 0 blanks the digit.
- dig_sel  out  DIGITS  one-hot active-low digit select.

## Operation
- FSM states: IDLE, CONV, DONE.
  - IDLE: if start=1, load shift register = {4*DIGITS zeros, bin}, set bit counter = WIDTH, compare bin against 10^DIGITS−1 into ovf_pending, then go to CONV. Otherwise stay in IDLE.
  - CONV: each cycle, add 3 to every BCD nibble ≥5, then shift the whole register left by 1 and decrement the counter. When the counter reaches 1 on the current cycle, go to DONE.
  - DONE: bcd_out ← BCD field, ovf ← ovf_pending, done=1, then go to IDLE.
- start is ignored in CONV and DONE; requests are not queued. bin is only sampled in IDLE.
- Carry out of the top digit is discarded. The truncated digits are undefined when ovf=1.
- Scanner runs free, independent of the FSM, and always displays the latched bcd_out.
  - A divider counts 0..SCAN_DIV−1. On wrap, the digit index increments modulo DIGITS.
  - dig_sel = ~(1<<index).
  - {W,X,Y,Z} = bcd_out nibble[index].
- Blanking rules for en:
  - Leading-zero blanking: en=0 for digit i>0 when nibble i and all nibbles above it are 0.
  - Digit 0 is never blanked by the zero rule.
  - ovf=1 forces en=0 on all digits.
  - ovf clears on the next in-range conversion.

## Timing
- Reset values: busy=0, done=0, ovf=0, bcd_out=0, FSM=IDLE, divider=0, index=0.
  - dig_sel = all ones except bit 0 = 0.
  - W=X=Y=Z=0, en=1, so the display shows "0" on digit 0.
- Conversion timing, with start high at edge 0:
  - busy=1 from after edge 0 through the CONV cycles.
  - DONE occupies cycle WIDTH+1. done=1 and busy=0 in that cycle, with the new bcd_out/ovf visible.
  - Total latency is WIDTH+1 cycles. The next start is accepted at the first edge after done.
- busy=1 throughout CONV, and 0 in IDLE and DONE.
- W,X,Y,Z, en and dig_sel are registered and update one cycle after a change in index or bcd_out.
- Each digit is held for exactly SCAN_DIV cycles. The full frame is DIGITS*SCAN_DIV cycles.
- Asynchronous reset mid-conversion aborts immediately. Outputs go to reset values, and bcd_out is not updated.

## Test plan
- Reset, then no start, SCAN_DIV=4 → dig_sel cycles 1110,1101,1011,0111 at 4 cycles each. Digit 0 shows WXYZ=0000 with en=1; digits 1–3 have en=0.
- start with bin=1234 → busy for 14 cycles, done pulse at cycle 15, bcd_out=0x1234, ovf=0. Scan shows nibbles 4,3,2,1, all with en=1.
- bin=9999 → bcd_out=0x9999, ovf=0. Then bin=10000 → done at cycle 15, ovf=1, en=0 on every digit. Then bin=7 → ovf=0, bcd_out=0x0007, only digit 0 enabled.
- bin=0x3FFF (16383) → ovf=1. Then bin=305 → bcd_out=0x0305; digit 2 is enabled and digit 1 (value 0) is enabled because it is not leading; digit 3 is blanked.
- start held high continuously with bin changing each cycle → exactly one conversion per 15+1 cycles, each using the bin value sampled in IDLE.
- rst_n low at cycle 5 of the conversion of 4321 → busy=0 and bcd_out=0 immediately. No done pulse; the next start converts normally.
